wb_priority_arbiter: RTL and testbench
======================================

Name: wb_priority_arbiter

Overview:
- Parametrised writeback arbiter between N execute-stage functional units and the EXE/MEM register.
- Successor to the fixed 7-unit priority controller.
- Keeps fixed index priority (index 0 highest), per-unit collision stalls and WAW id_exe clear.
- Adds per-unit age counters: a unit losing arbitration for STARVE_LIMIT consecutive cycles is promoted above fixed priority. Adds a flush input.

Parameters:
- NUM_UNITS, 7, total functional units requesting writeback. Index 0 has highest fixed priority.
- NUM_PIPED, 5, units 0..NUM_PIPED-1 are pipelined, stallable and issue start pulses. Legal range 1..NUM_UNITS.
- STARVE_LIMIT, 4, consecutive lost cycles before promotion. 0 disables aging (pure fixed priority).
- AGE_W, $clog2(STARVE_LIMIT+1) (minimum 1), age counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; clears all age counters
- req  in  NUM_UNITS  unit i has a result ready for EXE/MEM this cycle
- start  in  NUM_PIPED  pipelined unit i accepted a new op this cycle
- grant  out  NUM_UNITS  one-hot writeback select
- grant_idx  out  $clog2(NUM_UNITS)  binary index of the granted unit; 0 when none
- grant_valid  out  1  any grant
- stall  out  NUM_PIPED+1  bit i (i<NUM_PIPED) stalls unit i; bit NUM_PIPED stalls the system pipeline
- id_exe_clr  out  1  ORed into the id_exe register clear

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on port reset.
- Outputs are combinational from req, start and the registered ages. Zero-cycle arbitration latency.
- Age state: age[i] is AGE_W bits, registered.
  - Next value is 0 if reset, flush, !req[i] or grant[i].
  - Otherwise it is min(age[i]+1, STARVE_LIMIT), saturating with no wrap.
- starving[i] = (STARVE_LIMIT!=0) & req[i] & (age[i]==STARVE_LIMIT).
- Grant selection:
  - If any starving bit is set, grant the lowest-index starving unit.
  - Else, if req is non-zero, grant the lowest-index requester.
  - Else grant=0, grant_valid=0.
- collision = popcount(req) >= 2, evaluated over the full NUM_UNITS width (no truncation).
- Stalls:
  - stall[i] = collision & !grant[i] for i < NUM_PIPED.
  - stall[NUM_PIPED] = collision.
- Units with index >= NUM_PIPED hold their req under the system stall. The arbiter never stalls them individually.
- WAW clear:
  - copy_hazard = start & req[NUM_PIPED-1:0].
  - id_exe_clr = collision & |(grant[NUM_PIPED-1:0] & copy_hazard).
- Reset behaviour:
  - While reset is high, grant, grant_idx, grant_valid, stall and id_exe_clr are forced to 0 regardless of req.
  - On the next edge all ages are 0. Reset mid-collision therefore drops all stalls immediately.
- Boundary conditions:
  - Single requester: granted, no stall, id_exe_clr=0, its age stays 0.
  - flush and req in the same cycle: arbitration uses current ages; ages clear on the edge.
  - Two units starving simultaneously: lower index wins. The loser stays saturated and wins next cycle unless a lower-index starving unit appears.
  - STARVE_LIMIT=0: age logic is optimised away and behaviour is pure fixed priority.
  - NUM_PIPED==NUM_UNITS is legal: there is no non-stallable unit.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- When defined, adds outputs perf_stall_cycles[31:0] and perf_promotions[31:0].
  - perf_stall_cycles increments every cycle with collision=1.
  - perf_promotions increments every cycle in which the grant came from the starving path.
  - Both are reset and flush-independent, clear only on reset, and wrap from 0xFFFFFFFF to 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package wb_arb_pkg holds:
  - localparam defaults DEF_NUM_UNITS=7, DEF_NUM_PIPED=5.
  - Unit index constants: FDIVU=0, FMULU=1, FADD_SUBU=2, DIVU=3, MULU=4, FPU=5, ALU=6.
  - A typedef for the unit index, for mux select at the EXE/MEM register.
- One sub-module, wb_prio_pick: parametrised lowest-index-first one-hot picker with binary index output. It is instantiated twice, once over starving and once over req.

Test Plan:
- NUM_UNITS=7, NUM_PIPED=5, STARVE_LIMIT=4.
- req=7'b1000100 -> grant=7'b0000100, grant_idx=2, stall=6'b111011, id_exe_clr=0.
- req=7'b0001001, start=5'b00001 -> grant unit 0, stall=6'b111110, id_exe_clr=1. Same with start=0 -> id_exe_clr=0.
- req=7'b0000011 held 5 cycles -> grant unit 0 for cycles 0-3. Cycle 4: unit 1 starving, grant=7'b0000010, stall[0]=1. Cycle 5: unit 0 granted again, age[1]=0.
- Hold req=7'b0000011 for 3 cycles, pulse flush, continue -> unit 1 promotion delayed until 4 further lost cycles.
- Collision active, assert reset for 1 cycle -> all outputs 0 that cycle. After release with req=7'b0000011, unit 0 wins (ages cleared).
- With WB_ARB_PERF_EN, run the starvation scenario above -> perf_stall_cycles=5, perf_promotions=1. Preload near wrap via long collision run -> counter wraps to 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the writeback priority arbiter.
package wb_arb_pkg;

   localparam int unsigned DEF_NUM_UNITS    = 7;
   localparam int unsigned DEF_NUM_PIPED    = 5;
   localparam int unsigned DEF_STARVE_LIMIT = 4;

   typedef enum logic [2:0] {
      FDIVU     = 3'd0,
      FMULU     = 3'd1,
      FADD_SUBU = 3'd2,
      DIVU      = 3'd3,
      MULU      = 3'd4,
      FPU       = 3'd5,
      ALU       = 3'd6
   } unit_e;

   // Mux select at the EXE/MEM register for the default unit set.
   typedef logic [$clog2(DEF_NUM_UNITS)-1:0] unit_idx_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_priority_arbiter_if.sv
// Writeback request/grant bundle between the functional units and the arbiter.
interface wb_priority_arbiter_if
   import wb_arb_pkg::*;
#(
   parameter int unsigned NUM_UNITS = DEF_NUM_UNITS,
   parameter int unsigned NUM_PIPED = DEF_NUM_PIPED,
   parameter int unsigned IDX_W     = idx_width(NUM_UNITS)
);
   logic                 flush;
   logic [NUM_UNITS-1:0] req;
   logic [NUM_PIPED-1:0] start;
   logic [NUM_UNITS-1:0] grant;
   logic [IDX_W-1:0]     grant_idx;
   logic                 grant_valid;
   logic [NUM_PIPED:0]   stall;
   logic                 id_exe_clr;

   modport master (
      output flush, req, start,
      input  grant, grant_idx, grant_valid, stall, id_exe_clr
   );

   modport slave (
      input  flush, req, start,
      output grant, grant_idx, grant_valid, stall, id_exe_clr
   );
endinterface

// File: rtl/wb_prio_pick.sv
// Lowest-index-first one-hot picker with binary index of the selected bit.
module wb_prio_pick #(
   parameter int unsigned N     = 7,
   parameter int unsigned IDX_W = 3
) (
   input  logic [N-1:0]     vec,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (vec[i] && !any) begin
            onehot[i] = 1'b1;
            idx       = IDX_W'(i);
            any       = 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_priority_arbiter.sv
// Writeback arbiter: fixed index priority with age-based starvation promotion.
// Optional perf counters are built when WB_ARB_PERF_EN is defined.
module wb_priority_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned NUM_UNITS    = DEF_NUM_UNITS,
   parameter int unsigned NUM_PIPED    = DEF_NUM_PIPED,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int unsigned AGE_W        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
   input  logic clk,
   input  logic reset,
   wb_priority_arbiter_if.slave bus
`ifdef WB_ARB_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_promotions
`endif
);
   localparam int unsigned IDX_W = idx_width(NUM_UNITS);

   logic [NUM_UNITS-1:0] starving, starve_oh, req_oh, grant_raw;
   logic [IDX_W-1:0]     starve_idx, req_idx, idx_raw;
   logic                 starve_any, req_any, collision;
   logic [NUM_PIPED-1:0] copy_hazard;

   generate
      if (STARVE_LIMIT == 0) begin : g_no_age
         assign starving = '0;
      end else begin : g_age
         localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);
         logic [AGE_W-1:0] age [NUM_UNITS];

         always_ff @(posedge clk) begin
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
               if (reset || bus.flush || !bus.req[i] || grant_raw[i])
                  age[i] <= '0;
               else if (age[i] != LIMIT)
                  age[i] <= age[i] + 1'b1;
            end
         end

         always_comb begin
            starving = '0;
            for (int unsigned i = 0; i < NUM_UNITS; i++)
               starving[i] = bus.req[i] && (age[i] == LIMIT);
         end
      end
   endgenerate

   wb_prio_pick #(.N(NUM_UNITS), .IDX_W(IDX_W)) u_pick_starve (
      .vec(starving), .onehot(starve_oh), .idx(starve_idx), .any(starve_any)
   );

   wb_prio_pick #(.N(NUM_UNITS), .IDX_W(IDX_W)) u_pick_req (
      .vec(bus.req), .onehot(req_oh), .idx(req_idx), .any(req_any)
   );

   // Clearing the lowest set bit leaves a non-zero residue iff two or more bits are set.
   assign collision   = |(bus.req & (bus.req - 1'b1));
   assign grant_raw   = starve_any ? starve_oh : req_oh;
   assign idx_raw     = starve_any ? starve_idx : req_idx;
   assign copy_hazard = bus.start & bus.req[NUM_PIPED-1:0];

   always_comb begin
      bus.grant       = '0;
      bus.grant_idx   = '0;
      bus.grant_valid = 1'b0;
      bus.stall       = '0;
      bus.id_exe_clr  = 1'b0;
      if (!reset) begin
         bus.grant       = grant_raw;
         bus.grant_idx   = idx_raw;
         bus.grant_valid = req_any;
         bus.stall       = {collision, {NUM_PIPED{collision}} & ~grant_raw[NUM_PIPED-1:0]};
         bus.id_exe_clr  = collision && |(grant_raw[NUM_PIPED-1:0] & copy_hazard);
      end
   end

`ifdef WB_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_cycles <= '0;
         perf_promotions   <= '0;
      end else begin
         if (collision)  perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (starve_any) perf_promotions   <= perf_promotions + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_priority_arbiter.sv
// Directed and randomised checks of wb_priority_arbiter against a scoreboard of expected outputs.
module tb_wb_priority_arbiter;
   localparam int unsigned NU = 7;
   localparam int unsigned NP = 5;
   localparam int unsigned LIM = 4;

   logic clk = 1'b0;
   logic reset;
   int unsigned total = 0;
   int unsigned bad = 0;

   logic [17:0] expq [$];
   string       tagq [$];
   int unsigned mage [NU];

   wb_priority_arbiter_if #(.NUM_UNITS(NU), .NUM_PIPED(NP)) bus ();

`ifdef WB_ARB_PERF_EN
   logic [31:0] perf_stall_cycles, perf_promotions;
`endif

   wb_priority_arbiter #(.NUM_UNITS(NU), .NUM_PIPED(NP), .STARVE_LIMIT(LIM)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef WB_ARB_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_promotions   (perf_promotions)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] pk(input logic [6:0] g, input logic [2:0] i, input logic v,
                                      input logic [5:0] st, input logic c);
      return {g, i, v, st, c};
   endfunction

   // Reference: grant, index, valid, stall, clear for the current model ages.
   function automatic logic [17:0] model_out(input logic [6:0] r, input logic [4:0] s, input logic rst);
      logic [6:0] sv, g;
      logic [2:0] idx;
      logic       coll, clr, found;
      logic [5:0] st;
      if (rst) return '0;
      sv = '0;
      for (int i = 0; i < NU; i++) sv[i] = r[i] && (mage[i] == LIM);
      g = '0; idx = '0; found = 1'b0;
      for (int i = 0; i < NU; i++)
         if (!found && sv[i]) begin g[i] = 1'b1; idx = 3'(i); found = 1'b1; end
      for (int i = 0; i < NU; i++)
         if (!found && r[i]) begin g[i] = 1'b1; idx = 3'(i); found = 1'b1; end
      coll = ($countones(r) >= 2);
      st   = coll ? {1'b1, ~g[4:0]} : 6'b0;
      clr  = coll && ((g[4:0] & s & r[4:0]) != 5'b0);
      return {g, idx, (r != 7'b0), st, clr};
   endfunction

   task automatic model_advance(input logic [6:0] r, input logic f, input logic rst, input logic [6:0] g);
      for (int i = 0; i < NU; i++) begin
         if (rst || f || !r[i] || g[i]) mage[i] = 0;
         else if (mage[i] < LIM) mage[i] = mage[i] + 1;
      end
   endtask

   task automatic check_out();
      logic [17:0] e, o;
      string t;
      e = expq.pop_front();
      t = tagq.pop_front();
      o = {bus.grant, bus.grant_idx, bus.grant_valid, bus.stall, bus.id_exe_clr};
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s got grant=%b idx=%0d valid=%b stall=%b clr=%b exp grant=%b idx=%0d valid=%b stall=%b clr=%b",
                t, o[17:11], o[10:8], o[7], o[6:1], o[0], e[17:11], e[10:8], e[7], e[6:1], e[0]);
      end
   endtask

   task automatic apply(input logic [6:0] r, input logic [4:0] s, input logic f, input logic rst,
                        input logic [17:0] e, input string tag, input bit use_model);
      logic [17:0] m;
      @(negedge clk);
      bus.req = r; bus.start = s; bus.flush = f; reset = rst;
      m = model_out(r, s, rst);
      expq.push_back(use_model ? m : e);
      tagq.push_back(tag);
      #2;
      check_out();
      model_advance(r, f, rst, m[17:11]);
   endtask

   logic [17:0] G0, G1, G2, Z;
   logic [6:0]  rr;
   logic [4:0]  ss;
   logic        ff, rs;

   initial begin
      G0 = pk(7'b0000001, 3'd0, 1'b1, 6'b111110, 1'b0);
      G1 = pk(7'b0000010, 3'd1, 1'b1, 6'b111101, 1'b0);
      G2 = pk(7'b0000100, 3'd2, 1'b1, 6'b111011, 1'b0);
      Z  = '0;
      reset = 1'b1; bus.req = '0; bus.start = '0; bus.flush = 1'b0;
      for (int i = 0; i < NU; i++) mage[i] = 0;

      apply(7'b0000011, 5'b0, 1'b0, 1'b1, Z, "reset0", 0);
      apply(7'b0000011, 5'b0, 1'b0, 1'b1, Z, "reset1", 0);

      // starvation: unit 1 promoted on the fifth lost cycle
      for (int c = 0; c < 4; c++) apply(7'b0000011, 5'b0, 1'b0, 1'b0, G0, "starve_pre", 0);
      apply(7'b0000011, 5'b0, 1'b0, 1'b0, G1, "starve_promo", 0);
`ifdef WB_ARB_PERF_EN
      @(posedge clk); #1;
      total++;
      assert (perf_stall_cycles === 32'd5) else begin
         bad++; $error("FAIL perf_stall got=%0d exp=5", perf_stall_cycles);
      end
      total++;
      assert (perf_promotions === 32'd1) else begin
         bad++; $error("FAIL perf_promo got=%0d exp=1", perf_promotions);
      end
`endif
      apply(7'b0000011, 5'b0, 1'b0, 1'b0, G0, "starve_after", 0);
      apply(7'b0000000, 5'b0, 1'b0, 1'b0, Z, "idle", 0);

      apply(7'b1000100, 5'b0, 1'b0, 1'b0, G2, "pattern_u2_u6", 0);
      apply(7'b0001001, 5'b00001, 1'b0, 1'b0, pk(7'b0000001, 3'd0, 1'b1, 6'b111110, 1'b1), "waw_clr", 0);
      apply(7'b0001001, 5'b00000, 1'b0, 1'b0, G0, "waw_nostart", 0);
      apply(7'b0000000, 5'b0, 1'b0, 1'b0, Z, "idle", 0);

      // flush three cycles in delays promotion by four further lost cycles
      for (int c = 0; c < 3; c++) apply(7'b0000011, 5'b0, 1'b0, 1'b0, G0, "flush_pre", 0);
      apply(7'b0000011, 5'b0, 1'b1, 1'b0, G0, "flush_cycle", 0);
      for (int c = 0; c < 4; c++) apply(7'b0000011, 5'b0, 1'b0, 1'b0, G0, "flush_post", 0);
      apply(7'b0000011, 5'b0, 1'b0, 1'b0, G1, "flush_promo", 0);
      apply(7'b0000000, 5'b0, 1'b0, 1'b0, Z, "idle", 0);

      // two units reach the limit together
      for (int c = 0; c < 4; c++) apply(7'b0000111, 5'b0, 1'b0, 1'b0, G0, "dual_pre", 0);
      apply(7'b0000111, 5'b0, 1'b0, 1'b0, G1, "dual_low_wins", 0);
      apply(7'b0000111, 5'b0, 1'b0, 1'b0, G2, "dual_loser_next", 0);
      apply(7'b0000111, 5'b0, 1'b0, 1'b0, G0, "dual_back_fixed", 0);
      apply(7'b0000000, 5'b0, 1'b0, 1'b0, Z, "idle", 0);

      // reset in the middle of a collision clears ages that were one step from starving
      for (int c = 0; c < 3; c++) apply(7'b0000011, 5'b0, 1'b0, 1'b0, G0, "rst_pre", 0);
      apply(7'b0000011, 5'b00011, 1'b0, 1'b1, Z, "rst_mid", 0);
      apply(7'b0000011, 5'b0, 1'b0, 1'b0, G0, "rst_release", 0);
      apply(7'b0000000, 5'b0, 1'b0, 1'b0, Z, "idle", 0);

      apply(7'b0100000, 5'b11111, 1'b0, 1'b0, pk(7'b0100000, 3'd5, 1'b1, 6'b0, 1'b0), "single_u5", 0);
      for (int c = 0; c < 5; c++)
         apply(7'b0000100, 5'b00100, 1'b0, 1'b0, pk(7'b0000100, 3'd2, 1'b1, 6'b0, 1'b0), "single_u2", 0);
      apply(7'b0000101, 5'b0, 1'b0, 1'b0, G0, "single_age_zero", 0);
      apply(7'b1000000, 5'b0, 1'b0, 1'b0, pk(7'b1000000, 3'd6, 1'b1, 6'b0, 1'b0), "single_u6", 0);

      rr = 7'b0000011;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) rr = 7'($urandom);
         ss = 5'($urandom);
         ff = ($urandom_range(0, 15) == 0);
         rs = ($urandom_range(0, 31) == 0);
         apply(rr, ss, ff, rs, Z, "random", 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
